// File: rtl/rflc_decoder_mc.sv
`default_nettype none
// ============================================================================
// Module   : rflc_decoder_mc
// Brief    : Multi-channel clocked request-delay decoder. Each 2-phase request
//            transition on rout is replayed on rin after a programmable delay
//            (long for rising, short for falling), as a toggle or a 1-cycle
//            pulse, with a one-deep pending slot and a sticky overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module rflc_decoder_mc #(
    parameter int CH          = 4,
    parameter int DW          = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] rout,
    input  logic [DW-1:0] dly_long,
    input  logic [DW-1:0] dly_short,
    input  logic          mode,
    input  logic          err_clr,
    output logic [CH-1:0] rin,
    output logic [CH-1:0] rin_edge,
    output logic [CH-1:0] busy,
    output logic [CH-1:0] err_overrun
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Request as seen in the clk domain.
    logic [CH-1:0] rout_s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign rout_s = rout;
        end else begin : g_sync
            // Any non-zero SYNC_STAGES builds the two-flop synchroniser.
            logic [CH-1:0] sync1_q;
            logic [CH-1:0] sync2_q;

            // Two-flop synchroniser on every request bit.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_q <= '0;
                    sync2_q <= '0;
                end else begin
                    sync1_q <= rout;
                    sync2_q <= sync1_q;
                end
            end

            assign rout_s = sync2_q;
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            state_t        state_q, state_d;
            logic [DW-1:0] cnt_q, cnt_d;
            logic          edge_q, edge_d;
            logic          pend_v_q, pend_v_d;
            logic          pend_edge_q, pend_edge_d;
            logic [DW-1:0] pend_cnt_q, pend_cnt_d;
            logic          prev_q;
            logic          rin_q, rin_d;
            logic          rin_edge_q, rin_edge_d;
            logic          busy_q, busy_d;
            logic          err_q, err_d;

            logic          ev;
            logic          ev_edge;
            logic [DW-1:0] ev_dly;
            logic          fire;
            logic          overrun;

            // A transition of the synchronised request is one event; its
            // delay is chosen by the direction it moved in.
            assign ev      = rout_s[gi] ^ prev_q;
            assign ev_edge = rout_s[gi];
            assign ev_dly  = rout_s[gi] ? dly_long : dly_short;

            // Next-state: countdown, fire, pending slot and overrun handling.
            always_comb begin
                state_d     = state_q;
                cnt_d       = cnt_q;
                edge_d      = edge_q;
                pend_v_d    = pend_v_q;
                pend_edge_d = pend_edge_q;
                pend_cnt_d  = pend_cnt_q;
                fire        = 1'b0;
                overrun     = 1'b0;

                case (state_q)
                    ST_IDLE: begin
                        if (ev) begin
                            cnt_d   = ev_dly;
                            edge_d  = ev_edge;
                            state_d = ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - DW'(1);
                            if (ev) begin
                                if (!pend_v_q) begin
                                    pend_v_d    = 1'b1;
                                    pend_edge_d = ev_edge;
                                    pend_cnt_d  = ev_dly;
                                end else begin
                                    overrun = 1'b1;
                                end
                            end
                        end else begin
                            fire = 1'b1;
                            if (pend_v_q) begin
                                // Pending event goes first; a coincident new
                                // event refills the slot it just vacated.
                                cnt_d  = pend_cnt_q;
                                edge_d = pend_edge_q;
                                if (ev) begin
                                    pend_edge_d = ev_edge;
                                    pend_cnt_d  = ev_dly;
                                end else begin
                                    pend_v_d = 1'b0;
                                end
                            end else if (ev) begin
                                cnt_d  = ev_dly;
                                edge_d = ev_edge;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase

                // Pulse mode forces rin low on any cycle without a fire.
                rin_d      = mode ? fire : (rin_q ^ fire);
                rin_edge_d = fire ? edge_q : rin_edge_q;
                // Set has priority over the shared clear.
                err_d      = (err_q & ~err_clr) | overrun;
                busy_d     = (state_d == ST_WAIT) | pend_v_d;
            end

            // Per-channel state and registered outputs.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q     <= ST_IDLE;
                    cnt_q       <= '0;
                    edge_q      <= 1'b0;
                    pend_v_q    <= 1'b0;
                    pend_edge_q <= 1'b0;
                    pend_cnt_q  <= '0;
                    prev_q      <= 1'b0;
                    rin_q       <= 1'b0;
                    rin_edge_q  <= 1'b0;
                    busy_q      <= 1'b0;
                    err_q       <= 1'b0;
                end else begin
                    state_q     <= state_d;
                    cnt_q       <= cnt_d;
                    edge_q      <= edge_d;
                    pend_v_q    <= pend_v_d;
                    pend_edge_q <= pend_edge_d;
                    pend_cnt_q  <= pend_cnt_d;
                    prev_q      <= rout_s[gi];
                    rin_q       <= rin_d;
                    rin_edge_q  <= rin_edge_d;
                    busy_q      <= busy_d;
                    err_q       <= err_d;
                end
            end

            assign rin[gi]         = rin_q;
            assign rin_edge[gi]    = rin_edge_q;
            assign busy[gi]        = busy_q;
            assign err_overrun[gi] = err_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_rflc_decoder_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_rflc_decoder_mc
// Brief    : Directed self-checking bench for rflc_decoder_mc, one instance
//            without and one with the request synchroniser.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rflc_decoder_mc;

    logic       clk;
    logic       rst_n;
    logic [3:0] rout0;
    logic [3:0] rout2;
    logic [3:0] dly_long;
    logic [3:0] dly_short;
    logic       mode;
    logic       err_clr;
    logic [3:0] rin0, rin_edge0, busy0, err0;
    logic [3:0] rin2, rin_edge2, busy2, err2;

    int n_tests;
    int n_fail;

    rflc_decoder_mc #(.CH(4), .DW(4), .SYNC_STAGES(0)) u_dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .rout        (rout0),
        .dly_long    (dly_long),
        .dly_short   (dly_short),
        .mode        (mode),
        .err_clr     (err_clr),
        .rin         (rin0),
        .rin_edge    (rin_edge0),
        .busy        (busy0),
        .err_overrun (err0)
    );

    rflc_decoder_mc #(.CH(4), .DW(4), .SYNC_STAGES(2)) u_dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .rout        (rout2),
        .dly_long    (dly_long),
        .dly_short   (dly_short),
        .mode        (mode),
        .err_clr     (err_clr),
        .rin         (rin2),
        .rin_edge    (rin_edge2),
        .busy        (busy2),
        .err_overrun (err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rout;
        logic       mode;
        logic [3:0] rin;
        logic [3:0] redge;
        logic [3:0] busy;
        logic [3:0] err;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        rout0     = 4'b0000;
        rout2     = 4'b0000;
        dly_long  = 4'd3;
        dly_short = 4'd0;
        mode      = 1'b0;
        err_clr   = 1'b0;

        // Rows: inputs before the edge, outputs expected just after it.
        // dly_long=3, dly_short=0 throughout the table.
        tbl[0]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        tbl[2]  = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        tbl[3]  = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        tbl[4]  = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        tbl[5]  = '{4'b0001, 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        tbl[6]  = '{4'b0011, 1'b0, 4'b0001, 4'b0001, 4'b0010, 4'b0000};
        tbl[7]  = '{4'b0011, 1'b0, 4'b0001, 4'b0001, 4'b0010, 4'b0000};
        tbl[8]  = '{4'b0011, 1'b0, 4'b0001, 4'b0001, 4'b0010, 4'b0000};
        tbl[9]  = '{4'b0011, 1'b0, 4'b0001, 4'b0001, 4'b0010, 4'b0000};
        tbl[10] = '{4'b0011, 1'b0, 4'b0011, 4'b0011, 4'b0000, 4'b0000};
        tbl[11] = '{4'b0001, 1'b1, 4'b0000, 4'b0011, 4'b0010, 4'b0000};
        tbl[12] = '{4'b0001, 1'b1, 4'b0010, 4'b0001, 4'b0000, 4'b0000};
        tbl[13] = '{4'b0001, 1'b1, 4'b0000, 4'b0001, 4'b0000, 4'b0000};

        // Reset values while rst_n is held low.
        repeat (2) @(posedge clk);
        #1;
        check("reset_dut0", {rin0, rin_edge0, busy0, err0}, 16'h0000);
        check("reset_dut2", {rin2, rin_edge2, busy2, err2}, 16'h0000);
        rst_n = 1'b1;

        // Single events: long rising on ch0, short falling pulse on ch1.
        for (int i = 0; i < 14; i++) begin
            rout0 = tbl[i].rout;
            mode  = tbl[i].mode;
            tick();
            check($sformatf("tbl[%0d].rin", i), rin0, tbl[i].rin);
            check($sformatf("tbl[%0d].rin_edge", i), rin_edge0, tbl[i].redge);
            check($sformatf("tbl[%0d].busy", i), busy0, tbl[i].busy);
            check($sformatf("tbl[%0d].err", i), err0, tbl[i].err);
        end

        // Pending buffer on ch2: events at E and E+2, fires at E+6 and E+12.
        mode      = 1'b0;
        dly_long  = 4'd5;
        dly_short = 4'd5;
        for (int k = 0; k < 15; k++) begin
            if (k == 0) rout0[2] = 1'b1;
            if (k == 2) rout0[2] = 1'b0;
            tick();
            check($sformatf("pend.rin2 k=%0d", k), rin0[2], (k >= 6 && k <= 11));
            check($sformatf("pend.busy2 k=%0d", k), busy0[2], (k <= 11));
        end
        check("pend.err2", err0[2], 1'b0);

        // Overrun on ch3: third event dropped; err_clr at E+10 clears it.
        for (int k = 0; k < 15; k++) begin
            if (k <= 2) rout0[3] = ~rout0[3];
            err_clr = (k == 10);
            tick();
            check($sformatf("ovr.rin3 k=%0d", k), rin0[3], (k >= 6 && k <= 11));
            check($sformatf("ovr.err3 k=%0d", k), err0[3], (k >= 2 && k <= 9));
            if (k == 6)  check("ovr.edge3_first", rin_edge0[3], 1'b1);
            if (k == 12) check("ovr.edge3_second", rin_edge0[3], 1'b0);
        end
        err_clr = 1'b0;

        // Overrun coinciding with err_clr: set wins. ch1 rises alongside.
        for (int k = 0; k < 15; k++) begin
            if (k <= 2) rout0[3] = ~rout0[3];
            if (k == 0) rout0[1] = 1'b1;
            err_clr = (k == 2);
            tick();
            check($sformatf("ovrclr.err3 k=%0d", k), err0[3], (k >= 2));
            check($sformatf("ovrclr.rin3 k=%0d", k), rin0[3], (k >= 6 && k <= 11));
        end
        err_clr = 1'b0;
        check("ovrclr.rin1", rin0[1], 1'b1);

        // Reset mid-operation on ch0: cnt=2 with pending full and an overrun.
        for (int k = 0; k < 4; k++) begin
            if (k <= 2) rout0[0] = ~rout0[0];
            tick();
        end
        check("rstmid.busy0_before", busy0[0], 1'b1);
        check("rstmid.err0_before", err0[0], 1'b1);
        rst_n = 1'b0;
        rout0 = 4'b0000;
        #1;
        check("rstmid.rin", rin0, 4'b0000);
        check("rstmid.busy", busy0, 4'b0000);
        check("rstmid.err", err0, 4'b0000);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            check($sformatf("rstquiet k=%0d", k), {rin0, busy0}, 8'h00);
        end

        // Release with rout[0] high: one rising event, fires at E+6.
        rst_n = 1'b0;
        rout0 = 4'b0001;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("rsthigh.rin0 k=%0d", k), rin0[0], (k >= 6));
            check($sformatf("rsthigh.busy0 k=%0d", k), busy0[0], (k <= 5));
            if (k == 6) check("rsthigh.edge0", rin_edge0[0], 1'b1);
        end

        // Synchronised instance: all channels, zero delay -> rin at E+3.
        dly_long  = 4'd0;
        dly_short = 4'd0;
        rout2     = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("sync0.rin k=%0d", k), rin2, (k >= 3) ? 4'b1111 : 4'b0000);
        end

        // Maximum delay 15 through the synchroniser -> rin at E+18.
        dly_long  = 4'd15;
        dly_short = 4'd15;
        rout2     = 4'b1110;
        for (int k = 0; k < 20; k++) begin
            tick();
            check($sformatf("syncmax.rin k=%0d", k), rin2, (k >= 18) ? 4'b1110 : 4'b1111);
        end
        check("syncmax.busy", busy2, 4'b0000);
        check("syncmax.edge", rin_edge2, 4'b1110);
        check("syncmax.err", err2, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
